result_drain_packer: RTL and testbench

- Downstream stage of the CNN core.
- Drains the core's result buffer through its read_enable/valid/empty handshake, applies optional ReLU and a right-shift requantisation with saturation, and packs PACK results per word.
- Writes the packed words to the output feature-map memory through a ready/enable write port.
- Signals completion once a programmed number of results has been written.

---
 rtl/result_drain_packer.sv | 167 ++++++++++++++++
 tb/tb_result_drain_packer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain_packer.sv
// Result drain and packer. Reads results from the core's result buffer one at a time.
// Each result goes through optional ReLU, an arithmetic right shift and saturation.
// PACK results are packed into each output word, and the words are written to the
// output feature-map memory.
module result_drain_packer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned PACK        = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned SHIFT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [COUNT_WIDTH-1:0]    total_count,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic                      relu_en,
  input  logic [SHIFT_WIDTH-1:0]    shift,
  input  logic [DATA_WIDTH-1:0]     result_buffer_out,
  input  logic                      result_buffer_empty,
  input  logic                      result_buffer_valid,
  output logic                      result_buffer_read_enable,
  output logic                      mem_wen,
  output logic [ADDR_WIDTH-1:0]     mem_waddr,
  output logic [PACK*OUT_WIDTH-1:0] mem_wdata,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      done,
  output logic [COUNT_WIDTH-1:0]    sat_count
);

  localparam int unsigned LaneW = (PACK > 1) ? $clog2(PACK) : 1;
  // One spare bit over the wider of input/output so the clamp compares never overflow.
  localparam int unsigned ExtW  = ((DATA_WIDTH > OUT_WIDTH) ? DATA_WIDTH : OUT_WIDTH) + 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(PACK - 1);
  localparam logic signed [ExtW-1:0] OutMax = ExtW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ExtW-1:0] OutMin = ~OutMax;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StFlush, StDone} state_e;

  state_e                    state_q, state_d;
  logic [COUNT_WIDTH-1:0]    total_q, total_d;
  logic [COUNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]    sat_q, sat_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      relu_q, relu_d;
  logic [SHIFT_WIDTH-1:0]    shift_q, shift_d;
  logic [LaneW-1:0]          lane_idx_q, lane_idx_d;
  logic [PACK*OUT_WIDTH-1:0] lanes_q, lanes_d;

  logic signed [ExtW-1:0] ext_v, relu_v, shr_v;
  logic                   sat_hi, sat_lo, lane_sat;
  logic [OUT_WIDTH-1:0]   lane_val;

  // Requantise the incoming result: sign-extend, ReLU, shift, saturate.
  always_comb begin
    ext_v    = {{(ExtW - DATA_WIDTH){result_buffer_out[DATA_WIDTH-1]}}, result_buffer_out};
    relu_v   = (relu_q && ext_v[ExtW-1]) ? '0 : ext_v;
    shr_v    = relu_v >>> shift_q;
    sat_hi   = shr_v > OutMax;
    sat_lo   = shr_v < OutMin;
    lane_sat = sat_hi || sat_lo;
    if (sat_hi) begin
      lane_val = OutMax[OUT_WIDTH-1:0];
    end else if (sat_lo) begin
      lane_val = OutMin[OUT_WIDTH-1:0];
    end else begin
      lane_val = shr_v[OUT_WIDTH-1:0];
    end
  end

  // Next-state logic for the drain FSM and its datapath registers.
  always_comb begin
    state_d                   = state_q;
    total_d                   = total_q;
    cnt_d                     = cnt_q;
    sat_d                     = sat_q;
    addr_d                    = addr_q;
    relu_d                    = relu_q;
    shift_d                   = shift_q;
    lane_idx_d                = lane_idx_q;
    lanes_d                   = lanes_q;
    result_buffer_read_enable = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          total_d    = total_count;
          addr_d     = base_addr;
          relu_d     = relu_en;
          shift_d    = shift;
          sat_d      = '0;
          cnt_d      = '0;
          lane_idx_d = '0;
          lanes_d    = '0;
          state_d    = (total_count == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        if (!result_buffer_empty) begin
          result_buffer_read_enable = 1'b1;
          state_d                   = StWait;
        end
      end
      StWait: begin
        if (result_buffer_valid) begin
          lanes_d[lane_idx_q*OUT_WIDTH +: OUT_WIDTH] = lane_val;
          cnt_d = cnt_q + 1'b1;
          if (lane_sat && (sat_q != '1)) begin
            sat_d = sat_q + 1'b1;
          end
          if ((lane_idx_q == LastLane) || (cnt_d == total_q)) begin
            state_d = StFlush;
          end else begin
            lane_idx_d = lane_idx_q + 1'b1;
            state_d    = StReq;
          end
        end
      end
      StFlush: begin
        if (mem_ready) begin
          addr_d     = addr_q + 1'b1;
          lanes_d    = '0;
          lane_idx_d = '0;
          state_d    = (cnt_q == total_q) ? StDone : StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any drain in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      total_q    <= '0;
      cnt_q      <= '0;
      sat_q      <= '0;
      addr_q     <= '0;
      relu_q     <= 1'b0;
      shift_q    <= '0;
      lane_idx_q <= '0;
      lanes_q    <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      addr_q     <= addr_d;
      relu_q     <= relu_d;
      shift_q    <= shift_d;
      lane_idx_q <= lane_idx_d;
      lanes_q    <= lanes_d;
    end
  end

  // Status and write-port outputs come straight from registers.
  always_comb begin
    busy      = (state_q == StReq) || (state_q == StWait) || (state_q == StFlush);
    done      = (state_q == StDone);
    mem_wen   = (state_q == StFlush);
    mem_waddr = addr_q;
    mem_wdata = lanes_q;
    sat_count = sat_q;
  end

endmodule

// File: tb/tb_result_drain_packer.sv
// Self-checking bench for result_drain_packer. It uses 16-bit input data so that saturation occurs.
// A negedge responder models the result buffer and the memory and captures writes.
// Directed table vectors and randomized drains are checked against a behavioural model.
module tb_result_drain_packer;
  localparam int DW = 16;
  localparam int OW = 8;
  localparam int P  = 4;
  localparam int AW = 8;
  localparam int CW = 16;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [CW-1:0]   total_count;
  logic [AW-1:0]   base_addr;
  logic            relu_en;
  logic [SW-1:0]   shift;
  logic [DW-1:0]   rb_out;
  logic            rb_empty;
  logic            rb_valid;
  logic            rb_re;
  logic            mem_wen;
  logic [AW-1:0]   mem_waddr;
  logic [P*OW-1:0] mem_wdata;
  logic            mem_ready;
  logic            busy;
  logic            done;
  logic [CW-1:0]   sat_count;

  result_drain_packer #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .PACK(P), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .SHIFT_WIDTH(SW)
  ) dut (
    .clk                      (clk),
    .reset                    (rst_n),
    .start                    (start),
    .total_count              (total_count),
    .base_addr                (base_addr),
    .relu_en                  (relu_en),
    .shift                    (shift),
    .result_buffer_out        (rb_out),
    .result_buffer_empty      (rb_empty),
    .result_buffer_valid      (rb_valid),
    .result_buffer_read_enable(rb_re),
    .mem_wen                  (mem_wen),
    .mem_waddr                (mem_waddr),
    .mem_wdata                (mem_wdata),
    .mem_ready                (mem_ready),
    .busy                     (busy),
    .done                     (done),
    .sat_count                (sat_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Environment state shared between the responder and the test sequence.
  logic [DW-1:0]   rb_q[$];
  logic [DW-1:0]   pend_data;
  int              pend_cnt = 0;
  int              lat = 1;
  int              empty_hold = 0;
  int              stall_hold = 0;
  bit              rand_ready = 0;
  int              rd_count = 0;
  logic [AW-1:0]   wr_addr_q[$];
  logic [P*OW-1:0] wr_data_q[$];
  bit              wen_prev = 0;
  logic [AW-1:0]   prev_addr;
  logic [P*OW-1:0] prev_data;
  logic [AW-1:0]   exp_addr_q[$];
  logic [P*OW-1:0] exp_data_q[$];
  int              exp_sat;
  logic [DW-1:0]   dq[$];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Result-buffer and memory responder: drives inputs at negedge, samples requests #1 later.
  initial begin : responder
    rb_valid  = 1'b0;
    rb_out    = '0;
    rb_empty  = 1'b1;
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_cnt > 0) begin
        pend_cnt--;
        rb_valid = (pend_cnt == 0);
        rb_out   = (pend_cnt == 0) ? pend_data : DW'($urandom);
      end else begin
        rb_valid = 1'b0;
        rb_out   = DW'($urandom);
      end
      if (empty_hold > 0) begin
        empty_hold--;
        rb_empty = 1'b1;
      end else begin
        rb_empty = (rb_q.size() == 0);
      end
      if (mem_wen && stall_hold > 0) begin
        stall_hold--;
        mem_ready = 1'b0;
      end else begin
        mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (rb_re) begin
        check("read_while_empty", rb_empty, 0);
        check("second_read_outstanding", pend_cnt, 0);
        rd_count++;
        pend_cnt  = lat;
        pend_data = (rb_q.size() > 0) ? rb_q.pop_front() : '0;
      end
      if (mem_wen) begin
        if (wen_prev) begin
          check("waddr_stable", mem_waddr, prev_addr);
          check("wdata_stable", mem_wdata, prev_data);
        end
        if (mem_ready) begin
          wr_addr_q.push_back(mem_waddr);
          wr_data_q.push_back(mem_wdata);
          wen_prev = 0;
        end else begin
          wen_prev  = 1;
          prev_addr = mem_waddr;
          prev_data = mem_wdata;
        end
      end else begin
        wen_prev = 0;
      end
    end
  end

  // Behavioural model: per-result requantisation with integer arithmetic, then pack by lane.
  task automatic build_expected(input int tot, input int base, input bit relu, input int sh,
                                input logic [DW-1:0] d[$]);
    logic [P*OW-1:0] word = '0;
    int v;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_sat = 0;
    for (int i = 0; i < tot; i++) begin
      v = int'($signed(d[i]));
      if (relu && v < 0) v = 0;
      v = v >>> sh;
      if (v > 127) begin v = 127; exp_sat++; end
      else if (v < -128) begin v = -128; exp_sat++; end
      word = word | (32'(v & 'hFF) << (8 * (i % P)));
      if ((i % P == P - 1) || (i == tot - 1)) begin
        exp_data_q.push_back(word);
        exp_addr_q.push_back(AW'(base + i / P));
        word = '0;
      end
    end
  endtask

  task automatic pulse_start(input int tot, input int base, input bit relu, input int sh);
    @(negedge clk);
    start       = 1'b1;
    total_count = CW'(tot);
    base_addr   = AW'(base);
    relu_en     = relu;
    shift       = SW'(sh);
    @(negedge clk);
    start = 1'b0;
    // Scramble config inputs so that any unlatched use of them is exposed.
    total_count = CW'($urandom);
    base_addr   = AW'($urandom);
    relu_en     = 1'($urandom);
    shift       = SW'($urandom);
  endtask

  task automatic run_and_check(input string name, input int tot, input int base, input bit relu,
                               input int sh, input int exp_cyc, input bit mid_start);
    int cyc = 0;
    rd_count = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(tot, base, relu, sh);
    if (tot > 0) check({name, "_busy"}, busy, 1);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mid_start && cyc == 3) begin
        start = 1'b1; total_count = 1; base_addr = 8'h55; relu_en = !relu; shift = 7;
        @(negedge clk);
        cyc++;
        start = 1'b0;
      end
    end
    check({name, "_done_timeout"}, done, 1);
    if (exp_cyc >= 0) check({name, "_latency"}, cyc, exp_cyc);
    repeat (2) @(negedge clk);
    check({name, "_done_hold"}, done, 1);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_write_count"}, wr_data_q.size(), exp_data_q.size());
    for (int i = 0; i < exp_data_q.size() && i < wr_data_q.size(); i++) begin
      check({name, $sformatf("_waddr%0d", i)}, wr_addr_q[i], exp_addr_q[i]);
      check({name, $sformatf("_wdata%0d", i)}, wr_data_q[i], exp_data_q[i]);
    end
    check({name, "_read_count"}, rd_count, tot);
    check({name, "_sat_count"}, sat_count, exp_sat);
  endtask

  typedef struct {
    int              tot;
    int              base;
    bit              relu;
    int              sh;
    logic [7:0][15:0] d;
    int              nw;
    logic [1:0][31:0] w;
    logic [1:0][7:0]  a;
    int              sat;
  } vec_t;

  vec_t vecs[4];
  vec_t v;

  initial begin : main
    int cyc;
    int tot;
    int base;
    bit relu;
    int sh;
    vecs[0] = '{tot: 4, base: 'h10, relu: 0, sh: 0,
                d: {16'h0, 16'h0, 16'h0, 16'h0, 16'h4, 16'h3, 16'h2, 16'h1},
                nw: 1, w: {32'h0, 32'h04030201}, a: {8'h0, 8'h10}, sat: 0};
    vecs[1] = '{tot: 6, base: 'h20, relu: 1, sh: 0,
                d: {16'h0, 16'h0, 16'h3, 16'h2, 16'h1, 16'hFFFF, 16'h7F, 16'hFF80},
                nw: 2, w: {32'h00000302, 32'h01007F00}, a: {8'h21, 8'h20}, sat: 0};
    vecs[2] = '{tot: 2, base: 'h30, relu: 0, sh: 2,
                d: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hE000, 16'h1000},
                nw: 1, w: {32'h0, 32'h0000807F}, a: {8'h0, 8'h30}, sat: 2};
    vecs[3] = '{tot: 8, base: 'hFF, relu: 0, sh: 0,
                d: {16'h8, 16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1},
                nw: 2, w: {32'h08070605, 32'h04030201}, a: {8'h00, 8'hFF}, sat: 0};

    rst_n = 1'b0;
    start = 1'b0;
    total_count = '0;
    base_addr = '0;
    relu_en = 1'b0;
    shift = '0;
    repeat (3) @(negedge clk);
    check("reset_read_enable", rb_re, 0);
    check("reset_wen", mem_wen, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sat", sat_count, 0);
    rst_n = 1'b1;

    // Reset while a write is stalled in flush.
    stall_hold = 100000;
    rb_q.push_back(16'h11);
    rb_q.push_back(16'h22);
    pulse_start(2, 'h40, 0, 0);
    cyc = 0;
    while (!mem_wen && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_flush_reached", mem_wen, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_read_enable", rb_re, 0);
    check("rst_mid_wen", mem_wen, 0);
    check("rst_mid_waddr", mem_waddr, 0);
    check("rst_mid_wdata", mem_wdata, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_sat", sat_count, 0);
    @(negedge clk);
    stall_hold = 0;
    pend_cnt = 0;
    rb_q.delete();
    rst_n = 1'b1;

    // Directed table; ideal handshake so the cycle count is 2*total + words.
    lat = 1;
    rand_ready = 0;
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      exp_addr_q.delete();
      exp_data_q.delete();
      for (int k = 0; k < v.nw; k++) begin
        exp_data_q.push_back(v.w[k]);
        exp_addr_q.push_back(v.a[k]);
      end
      exp_sat = v.sat;
      for (int k = 0; k < v.tot; k++) rb_q.push_back(v.d[k]);
      run_and_check($sformatf("vec%0d", i), v.tot, v.base, v.relu, v.sh,
                    2 * v.tot + v.nw, 0);
    end

    // Zero-length drain: done the cycle after start, with no traffic and counters cleared.
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_sat = 0;
    run_and_check("zero", 0, 'h77, 0, 0, 0, 0);

    // Empty buffer, slow valid and stalled memory.
    dq.delete();
    for (int k = 0; k < 4; k++) dq.push_back(DW'($urandom));
    build_expected(4, 'h60, 1, 3, dq);
    foreach (dq[k]) rb_q.push_back(dq[k]);
    lat = 3;
    empty_hold = 7;
    stall_hold = 4;
    run_and_check("stall", 4, 'h60, 1, 3, -1, 0);

    // Start pulsed mid-drain is ignored.
    dq.delete();
    for (int k = 0; k < 5; k++) dq.push_back(DW'($urandom));
    build_expected(5, 'h80, 0, 9, dq);
    foreach (dq[k]) rb_q.push_back(dq[k]);
    run_and_check("busy_start", 5, 'h80, 0, 9, -1, 1);

    // Randomized drains against the model.
    rand_ready = 1;
    for (int r = 0; r < 25; r++) begin
      tot  = $urandom_range(1, 13);
      base = $urandom_range(0, 255);
      relu = 1'($urandom);
      sh   = $urandom_range(0, 12);
      lat  = $urandom_range(1, 3);
      dq.delete();
      for (int k = 0; k < tot; k++) dq.push_back(DW'($urandom));
      build_expected(tot, base, relu, sh, dq);
      foreach (dq[k]) rb_q.push_back(dq[k]);
      run_and_check($sformatf("rand%0d", r), tot, base, relu, sh, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
